// File: rtl/mem_ctrler_pkg.sv
// Shared configuration for the external RAM controller: default geometry,
// byte/line/address types and the FSM and grant encodings.
package mem_ctrler_pkg;

    localparam int DEFAULT_LINE_BYTES = 16;
    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int CACHE_LINE_WIDTH   = $clog2(DEFAULT_LINE_BYTES);

    typedef logic [DEFAULT_ADDR_WIDTH-1:0]   addr_type;
    typedef logic [7:0]                      byte_type;
    typedef logic [8*DEFAULT_LINE_BYTES-1:0] cache_line_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_type;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_LS   = 1'b1
    } grant_type;

endpackage

// File: rtl/mem_ctrler_arbiter.sv
// Two-way round-robin grant between the i-cache and d-cache requesters;
// purely combinational, the caller owns the last_grant register.
module mem_ctrler_arbiter
    import mem_ctrler_pkg::*;
(
    input  logic valid_inst,
    input  logic valid_ls,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = valid_inst | valid_ls;
        grant       = GRANT_INST;
        if (valid_inst && valid_ls) begin
            // Contention: hand the port to whoever did not have it last.
            grant = (last_grant == GRANT_INST) ? GRANT_LS : GRANT_INST;
        end else if (valid_ls) begin
            grant = GRANT_LS;
        end
    end

endmodule

// File: rtl/mem_ctrler.sv
// Byte-wide external RAM owner: arbitrates i-cache and d-cache line requests
// and sequences each line read or write-back one byte per cycle.
module mem_ctrler
    import mem_ctrler_pkg::*;
#(
    parameter int LINE_BYTES = DEFAULT_LINE_BYTES,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    valid_from_inst_fetcher,
    input  logic [ADDR_WIDTH-1:0]   addr_from_inst_fetcher,
    output logic                    ready_to_inst_fetcher,
    input  logic                    valid_from_ls_buffer,
    input  logic                    rw_flag_from_ls_buffer,
    input  logic [ADDR_WIDTH-1:0]   addr_from_ls_buffer,
    input  logic [8*LINE_BYTES-1:0] cache_line_from_ls_buffer,
    output logic                    ready_to_ls_buffer,
    output logic [8*LINE_BYTES-1:0] cache_line_out,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    localparam int CLW = $clog2(LINE_BYTES);
    localparam int CW  = CLW + 1;
    localparam logic [CW-1:0]         LAST_RD   = CW'(LINE_BYTES);
    localparam logic [CW-1:0]         LAST_WR   = CW'(LINE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    state_type               state;
    logic [CW-1:0]           counter;
    logic                    last_grant;
    logic [ADDR_WIDTH-1:0]   base;
    logic [8*LINE_BYTES-1:0] line_buf;

    logic                    grant;
    logic                    grant_valid;
    logic [CW-1:0]           counter_m1;
    logic [CLW-1:0]          rd_idx;
    logic [CLW-1:0]          wr_idx;

    mem_ctrler_arbiter u_arbiter (
        .valid_inst  (valid_from_inst_fetcher),
        .valid_ls    (valid_from_ls_buffer),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        counter_m1 = counter - CW'(1);
        rd_idx     = counter_m1[CLW-1:0];
        wr_idx     = counter[CLW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            counter        <= '0;
            last_grant     <= GRANT_INST;
            base           <= '0;
            line_buf       <= '0;
            cache_line_out <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant;
                        counter    <= '0;
                        if (grant == GRANT_LS) begin
                            base     <= addr_from_ls_buffer & BASE_MASK;
                            line_buf <= cache_line_from_ls_buffer;
                            state    <= rw_flag_from_ls_buffer ? WRITE : READ;
                        end else begin
                            base  <= addr_from_inst_fetcher & BASE_MASK;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    // RAM data lags the address by one cycle, so step k stores byte k-1.
                    if (counter != '0) begin
                        cache_line_out[8*rd_idx +: 8] <= mem_din;
                    end
                    if (counter == LAST_RD) begin
                        state <= DONE;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                WRITE: begin
                    if (!io_buffer_full) begin
                        if (counter == LAST_WR) begin
                            state <= DONE;
                        end
                        counter <= counter + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state)
            READ: begin
                // While frozen, re-present the byte still owed so it is on mem_din at resume.
                if (!rdy && counter != '0) begin
                    mem_a = base + ADDR_WIDTH'(rd_idx);
                end else if (counter != LAST_RD) begin
                    mem_a = base + ADDR_WIDTH'(counter);
                end
            end
            WRITE: begin
                mem_a    = base + ADDR_WIDTH'(counter);
                mem_dout = line_buf[8*wr_idx +: 8];
                mem_wr   = rdy && !io_buffer_full;
            end
            default: begin
                mem_a = '0;
            end
        endcase
    end

    assign ready_to_inst_fetcher = (state == DONE) && (last_grant == GRANT_INST);
    assign ready_to_ls_buffer    = (state == DONE) && (last_grant == GRANT_LS);

endmodule

// File: tb/tb_mem_ctrler.sv
// Self-checking bench for mem_ctrler: RAM model with one-cycle read latency,
// request driver tasks, and a scoreboard of expected {requester, line} results.
module tb_mem_ctrler;

    localparam int LB = 16;
    localparam int AW = 32;
    localparam int LW = 8 * LB;
    localparam int EW = LW + 1;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic          valid_inst;
    logic [AW-1:0] addr_inst;
    logic          ready_inst;
    logic          valid_ls;
    logic          rw_ls;
    logic [AW-1:0] addr_ls;
    logic [LW-1:0] line_ls;
    logic          ready_ls;
    logic [LW-1:0] cache_line_out;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic          io_buffer_full;

    mem_ctrler #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .rdy                       (rdy),
        .valid_from_inst_fetcher   (valid_inst),
        .addr_from_inst_fetcher    (addr_inst),
        .ready_to_inst_fetcher     (ready_inst),
        .valid_from_ls_buffer      (valid_ls),
        .rw_flag_from_ls_buffer    (rw_ls),
        .addr_from_ls_buffer       (addr_ls),
        .cache_line_from_ls_buffer (line_ls),
        .ready_to_ls_buffer        (ready_ls),
        .cache_line_out            (cache_line_out),
        .mem_din                   (mem_din),
        .mem_dout                  (mem_dout),
        .mem_a                     (mem_a),
        .mem_wr                    (mem_wr),
        .io_buffer_full            (io_buffer_full)
    );

    // clock / reset / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // RAM model: byte at address a holds pat(a); read data one cycle after address
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] + (a[15:8] * 8'd7) + 8'h62;
    endfunction

    always @(posedge clk) mem_din <= pat(mem_a[15:0]);

    function automatic logic [LW-1:0] exp_line(input logic [15:0] base);
        logic [LW-1:0] r;
        for (int i = 0; i < LB; i++) r[8*i +: 8] = pat(base + 16'(i));
        return r;
    endfunction

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int            n_vec;
    int            n_err;
    logic [LW-1:0] last_line;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready_inst || ready_ls) begin
            check("dual_ready", EW'(ready_inst & ready_ls), EW'(0));
            if (exp_q.size() == 0) begin
                check("unexpected_ready", EW'(exp_q.size()), EW'(1));
            end else begin
                check("sb_line", {ready_ls, cache_line_out}, exp_q.pop_front());
            end
        end
    end

    // driver tasks and per-cycle traces
    logic [AW-1:0] a_tr [0:63];
    logic          wr_tr[0:63];
    logic [7:0]    d_tr [0:63];
    int            full_at, full_len, stall_at, stall_len;

    task automatic start_inst(input logic [AW-1:0] a);
        valid_inst = 1'b1;
        addr_inst  = a;
    endtask

    task automatic start_ls(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] line);
        valid_ls = 1'b1;
        rw_ls    = rw;
        addr_ls  = a;
        line_ls  = line;
    endtask

    // Cycle 0 is the cycle in which the request is first presented in IDLE.
    task automatic wait_done(input logic for_ls, input logic keep, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (c < 64) begin
                a_tr[c]  = mem_a;
                wr_tr[c] = mem_wr;
                d_tr[c]  = mem_dout;
            end
            if (for_ls ? ready_ls : ready_inst) begin
                seen = 1'b1;
                cyc  = c;
                if (!keep) begin
                    if (for_ls) valid_ls = 1'b0;
                    else        valid_inst = 1'b0;
                end
            end else begin
                io_buffer_full = (c + 1 >= full_at) && (c + 1 < full_at + full_len);
                rdy            = !((c + 1 >= stall_at) && (c + 1 < stall_at + stall_len));
            end
        end
        check("ready_timeout", EW'(seen), EW'(1));
    endtask

    task automatic check_write(input logic [AW-1:0] base, input logic [LW-1:0] line, input int cyc);
        int j;
        j = 0;
        for (int c = 0; c <= cyc && c < 64; c++) begin
            if (wr_tr[c]) begin
                if (j < LB) begin
                    check("wr_addr", EW'(a_tr[c]), EW'(base + AW'(j)));
                    check("wr_data", EW'(d_tr[c]), EW'(line[8*j +: 8]));
                end
                j++;
            end
        end
        check("wr_count", EW'(j), EW'(LB));
    endtask

    initial begin
        int            cyc, c1, c2, served, nrdy, hits;
        logic [2:0]    order;
        logic [LW-1:0] wline, l_a, l_b;

        n_vec = 0; n_err = 0; last_line = '0;
        full_at = 1000; full_len = 0; stall_at = 1000; stall_len = 0;
        rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        valid_inst = 1'b0; addr_inst = '0;
        valid_ls = 1'b0; rw_ls = 1'b0; addr_ls = '0; line_ls = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_inst", EW'(ready_inst), EW'(0));
        check("rst_ready_ls",   EW'(ready_ls),   EW'(0));
        check("rst_mem_a",      EW'(mem_a),      EW'(0));
        check("rst_mem_wr",     EW'(mem_wr),     EW'(0));
        check("rst_mem_dout",   EW'(mem_dout),   EW'(0));
        check("rst_line",       EW'(cache_line_out), EW'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // round robin from reset: LS, inst, LS
        @(posedge clk); #1;
        l_a = exp_line(16'h4000);
        l_b = exp_line(16'h5000);
        exp_q.push_back({1'b1, l_a});
        exp_q.push_back({1'b0, l_b});
        exp_q.push_back({1'b1, l_a});
        last_line = l_a;
        start_ls(1'b0, 32'h0000_4008, '0);
        start_inst(32'h0000_5004);
        served = 0;
        order  = '0;
        for (int c = 0; c < 300 && served < 3; c++) begin
            @(negedge clk);
            if (ready_inst || ready_ls) begin
                order = {order[1:0], ready_ls};
                served++;
                if (served == 3) begin
                    valid_ls   = 1'b0;
                    valid_inst = 1'b0;
                end
            end
        end
        check("rr_served", EW'(served), EW'(3));
        check("rr_order",  EW'(order),  EW'(3'b101));

        // timed inst read at 0x1234
        @(posedge clk); #1;
        l_a = exp_line(16'h1230);
        exp_q.push_back({1'b0, l_a});
        last_line = l_a;
        start_inst(32'h0000_1234);
        wait_done(1'b0, 1'b0, cyc);
        check("rd_ready_cycle", EW'(cyc), EW'(18));
        for (int n = 1; n <= LB; n++) check("rd_mem_a", EW'(a_tr[n]), EW'(32'h1230 + n - 1));
        check("rd_byte0",  EW'(cache_line_out[7:0]),     EW'(8'h10));
        check("rd_byte15", EW'(cache_line_out[127:120]), EW'(8'h1F));
        @(negedge clk);
        check("rd_ready_pulse", EW'(ready_inst), EW'(0));

        // LS write-back at 0x2000, bytes A0..AF
        @(posedge clk); #1;
        for (int i = 0; i < LB; i++) wline[8*i +: 8] = 8'hA0 + 8'(i);
        exp_q.push_back({1'b1, last_line});
        start_ls(1'b1, 32'h0000_2000, wline);
        wait_done(1'b1, 1'b0, cyc);
        check("wr_ready_cycle", EW'(cyc), EW'(17));
        check_write(32'h0000_2000, wline, cyc);
        check("wr_line_hold", EW'(cache_line_out), EW'(last_line));

        // write-back immediately followed by a read at 0x3000
        @(posedge clk); #1;
        wline = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back({1'b1, last_line});
        l_a = exp_line(16'h3000);
        exp_q.push_back({1'b1, l_a});
        last_line = l_a;
        start_ls(1'b1, 32'h0000_2080, wline);
        wait_done(1'b1, 1'b1, c1);
        check_write(32'h0000_2080, wline, c1);
        rw_ls   = 1'b0;
        addr_ls = 32'h0000_3000 + AW'($urandom_range(0, LB - 1));
        line_ls = {$urandom, $urandom, $urandom, $urandom};
        wait_done(1'b1, 1'b0, c2);
        check("chain_ready_cycle", EW'(c2),      EW'(18));
        check("chain_idle_a",      EW'(a_tr[0]), EW'(0));
        check("chain_first_a",     EW'(a_tr[1]), EW'(32'h3000));

        // back-pressure on byte 5 for 3 cycles
        @(posedge clk); #1;
        wline = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back({1'b1, last_line});
        full_at = 6; full_len = 3;
        start_ls(1'b1, 32'h0000_2100, wline);
        wait_done(1'b1, 1'b0, cyc);
        full_at = 1000; full_len = 0;
        io_buffer_full = 1'b0;
        check("full_ready_cycle", EW'(cyc), EW'(20));
        check_write(32'h0000_2100, wline, cyc);
        for (int c = 6; c <= 8; c++) check("full_wr_low", EW'(wr_tr[c]), EW'(0));
        hits = 0;
        for (int c = 0; c <= cyc; c++) if (wr_tr[c] && a_tr[c] == 32'h2105) hits++;
        check("full_byte5_once", EW'(hits), EW'(1));

        // rdy low for 4 cycles mid-read
        @(posedge clk); #1;
        l_a = exp_line(16'h6000);
        exp_q.push_back({1'b0, l_a});
        last_line = l_a;
        stall_at = 5; stall_len = 4;
        start_inst(32'h0000_600C);
        wait_done(1'b0, 1'b0, cyc);
        stall_at = 1000; stall_len = 0;
        rdy = 1'b1;
        check("stall_ready_cycle", EW'(cyc), EW'(22));
        check("stall_line", EW'(cache_line_out), EW'(l_a));

        // reset during READ step 8 aborts the transfer
        @(posedge clk); #1;
        start_inst(32'h0000_7000);
        nrdy = 0;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (ready_inst || ready_ls) nrdy++;
            if (c == 9) rst = 1'b0;
            if (c == 10) begin
                check("abort_mem_a",    EW'(mem_a),          EW'(0));
                check("abort_mem_wr",   EW'(mem_wr),         EW'(0));
                check("abort_mem_dout", EW'(mem_dout),       EW'(0));
                check("abort_ready",    EW'({ready_inst, ready_ls}), EW'(0));
                check("abort_line",     EW'(cache_line_out), EW'(0));
                rst        = 1'b1;
                valid_inst = 1'b0;
            end
        end
        last_line = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (ready_inst || ready_ls) nrdy++;
        end
        check("abort_no_ready", EW'(nrdy), EW'(0));

        // recovery read after the abort
        @(posedge clk); #1;
        l_a = exp_line(16'h1230);
        exp_q.push_back({1'b0, l_a});
        last_line = l_a;
        start_inst(32'h0000_123F);
        wait_done(1'b0, 1'b0, cyc);
        check("recover_ready_cycle", EW'(cyc), EW'(18));

        repeat (3) @(negedge clk);
        check("sb_drain", EW'(exp_q.size()), EW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
